// File: rtl/ct_ifu_bht_sel_ctrl.sv
// Access controller for the 128x16 BHT select array: init sweep, fetch reads, counter updates.
// Reads return data one cycle after rd_gnt; a buffered update blocked STARVE_MAX cycles by reads is forced.
module ct_ifu_bht_sel_ctrl #(
    parameter logic [15:0] INIT_VAL   = 16'h0000,
    parameter int          STARVE_MAX = 4
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        inv_req,
    output logic        inv_busy,
    output logic        inv_done,
    input  logic        rd_vld,
    input  logic [6:0]  rd_idx,
    output logic        rd_gnt,
    output logic        rd_data_vld,
    output logic [15:0] rd_data,
    input  logic        upd_vld,
    output logic        upd_rdy,
    input  logic [6:0]  upd_idx,
    input  logic [2:0]  upd_way,
    input  logic [1:0]  upd_cnt,
    input  logic        upd_taken,
    output logic        bht_sel_array_clk_en,
    output logic        bht_sel_array_cen_b,
    output logic        bht_sel_array_gwen,
    output logic [15:0] bht_sel_bwen,
    output logic [15:0] bht_sel_array_din,
    output logic [6:0]  bht_sel_array_index,
    input  logic [15:0] bht_sel_data_out
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {INIT, IDLE} state_t;

    state_t         state;
    logic [6:0]     ptr;
    logic           buf_vld;
    logic [6:0]     buf_idx;
    logic [2:0]     buf_way;
    logic [1:0]     buf_cnt;
    logic [SW-1:0]  starve_cnt;

    logic           force_wr;
    logic           acc_init;
    logic           acc_rd;
    logic           acc_wr;
    logic [1:0]     new_cnt;

    // Reset gates every access combinationally so nothing reaches the macro before the first edge.
    assign inv_busy = ~cpurst_b | (state == INIT);
    assign force_wr = buf_vld & (starve_cnt == STARVE_LIM);
    assign acc_init = cpurst_b & (state == INIT);
    assign acc_rd   = cpurst_b & (state == IDLE) & ~force_wr & rd_vld;
    assign acc_wr   = cpurst_b & (state == IDLE) & buf_vld & (force_wr | ~rd_vld);

    assign rd_gnt   = acc_rd;
    assign upd_rdy  = ~buf_vld & ~inv_busy;
    assign rd_data  = bht_sel_data_out;

    always_comb begin
        new_cnt = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != 2'd3) new_cnt = upd_cnt + 2'd1;
        end else begin
            if (upd_cnt != 2'd0) new_cnt = upd_cnt - 2'd1;
        end
    end

    always_comb begin
        bht_sel_array_cen_b = 1'b1;
        bht_sel_array_gwen  = 1'b1;
        bht_sel_bwen        = 16'hFFFF;
        bht_sel_array_din   = 16'h0000;
        bht_sel_array_index = 7'd0;
        if (acc_init) begin
            bht_sel_array_cen_b = 1'b0;
            bht_sel_array_gwen  = 1'b0;
            bht_sel_bwen        = 16'h0000;
            bht_sel_array_din   = INIT_VAL;
            bht_sel_array_index = ptr;
        end else if (acc_wr) begin
            // Single-field write: replicate the counter and let the mask pick the way.
            bht_sel_array_cen_b = 1'b0;
            bht_sel_array_gwen  = 1'b0;
            bht_sel_bwen        = ~(16'h0003 << {buf_way, 1'b0});
            bht_sel_array_din   = {8{buf_cnt}};
            bht_sel_array_index = buf_idx;
        end else if (acc_rd) begin
            bht_sel_array_cen_b = 1'b0;
            bht_sel_array_index = rd_idx;
        end
    end

    assign bht_sel_array_clk_en = ~bht_sel_array_cen_b | inv_busy;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state       <= INIT;
            ptr         <= 7'd0;
            inv_done    <= 1'b0;
            rd_data_vld <= 1'b0;
            buf_vld     <= 1'b0;
            buf_idx     <= 7'd0;
            buf_way     <= 3'd0;
            buf_cnt     <= 2'd0;
            starve_cnt  <= '0;
        end else begin
            rd_data_vld <= acc_rd;
            inv_done    <= 1'b0;
            case (state)
                INIT: begin
                    ptr        <= ptr + 7'd1;
                    buf_vld    <= 1'b0;
                    starve_cnt <= '0;
                    if (ptr == 7'd127) begin
                        state    <= IDLE;
                        inv_done <= 1'b1;
                    end
                end
                default: begin
                    if (inv_req) begin
                        state      <= INIT;
                        ptr        <= 7'd0;
                        buf_vld    <= 1'b0;
                        starve_cnt <= '0;
                    end else if (acc_wr) begin
                        buf_vld    <= 1'b0;
                        starve_cnt <= '0;
                    end else if (upd_vld && upd_rdy) begin
                        buf_vld    <= 1'b1;
                        buf_idx    <= upd_idx;
                        buf_way    <= upd_way;
                        buf_cnt    <= new_cnt;
                        starve_cnt <= '0;
                    end else if (buf_vld && acc_rd) begin
                        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
                    end else if (!buf_vld) begin
                        starve_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
